sim_frame_trigger: RTL and testbench
====================================

Name: sim_frame_trigger

Overview:
Produces the frame count and the waveform-dump window/finish controls consumed by the simulation dump controller in the game test harness. Watches the VGA vertical sync and the ROM-download indicator, counts frames only after download completes, and opens/closes a dump window at configured frame numbers. Sits between the video output of the game top and the dump/finish logic of the testbench; fully synthesizable so it can also drive an on-board capture trigger.

Parameters:
DUMP_START, 0, frame number whose VS falling edge opens the dump window
DUMP_LEN, 0, number of frames the window stays open; 0 = never closes
MAX_FRAMES, 0, frame count at which sim_finish asserts; 0 = never
WAIT_DL, 1, 1 = hold counting until downloading has been seen high then low; 0 = count from reset
CW, 32, frame counter width

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
vs  in  1  VGA vertical sync, asynchronous to clk, active low
downloading  in  1  ROM download in progress (LED signal), asynchronous
frame_cnt  out  CW  frames completed since download end
frame_stb  out  1  one-cycle pulse per counted VS falling edge
dump_on  out  1  level, high while dump window open
dump_start_stb  out  1  one-cycle pulse when window opens
dump_stop_stb  out  1  one-cycle pulse when window closes
sim_finish  out  1  sticky request to end simulation

Behaviour:
- Clock is clk; reset is asynchronous, active-low on rst_n. All outputs reset to 0; state resets to IDLE (WAIT_DL=1) or RUN (WAIT_DL=0).
- vs and downloading each pass through 2-flop synchronizers; falling-edge detect on synced vs. frame_stb fires on clk edge 3 after the first clk edge sampling vs low (2 sync + 1 edge register).
- States: IDLE, LOAD, RUN, DUMP, DONE.
  - IDLE: downloading_s high -> LOAD. No counting.
  - LOAD: downloading_s low -> RUN. No counting.
  - RUN: on vs fall: frame_cnt+1, frame_stb. If pre-increment frame_cnt == DUMP_START -> DUMP, dump_on=1, dump_start_stb same cycle as frame_stb.
  - DUMP: counts as RUN; internal window counter increments per frame; when DUMP_LEN!=0 and window count reaches DUMP_LEN -> RUN, dump_on=0, dump_stop_stb. DUMP_START is not re-matched afterwards (one-shot latch).
  - DONE: entered when MAX_FRAMES!=0 and post-increment frame_cnt == MAX_FRAMES; sim_finish=1 sticky; dump_on drops with dump_stop_stb if open; counting stops.
- MAX_FRAMES precedence over window close on same edge: a single dump_stop_stb, state DONE.
- downloading_s rising in RUN/DUMP: -> LOAD, frame_cnt held (not cleared), dump_on dropped with dump_stop_stb; one-shot latch and window count kept; on return to RUN, window reopens only if not yet opened.
- frame_cnt wraps modulo 2^CW; no finish or match on wrap unless values equal.
- Reset mid-window: all outputs 0 immediately, no stop pulse.
- Strobes are exactly one clk wide; vs pulses shorter than 2 clk may be missed (not required to count).

Decomposition:
- Package sim_trig_pkg: state enum (IDLE, LOAD, RUN, DUMP, DONE), CW default, SYNC_STAGES=2.
- Sub-module sim_vs_edge: 2-flop synchronizer plus falling-edge pulse, instanced for vs (edge) and downloading (level only).

Test Plan:
- WAIT_DL=1, 5 vs pulses before downloading, then downloading pulse, then 5 vs -> frame_cnt=5, exactly 5 frame_stb, each 3 clk after vs fall.
- DUMP_START=3, DUMP_LEN=2, 8 frames -> dump_start_stb with frame_stb taking cnt 3->4, dump_stop_stb at 5->6, dump_on high exactly 2 frames, never reopens.
- MAX_FRAMES=4, DUMP_START=2, DUMP_LEN=0 -> sim_finish at cnt 4 with one dump_stop_stb; further vs leaves frame_cnt=4.
- Downloading re-asserted at cnt 3 inside window -> dump_on falls with dump_stop_stb, cnt held at 3; after release counting resumes from 3, no reopen.
- CW=4, WAIT_DL=0, 17 frames -> frame_cnt wraps to 1, no sim_finish with MAX_FRAMES=0.
- rst_n low mid-window for 1 clk -> all outputs 0 asynchronously, no strobe; state IDLE.

Source files
------------

// File: rtl/sim_trig_pkg.sv
// Shared types and constants for the simulation frame trigger.
// Imported by the synchronizer/edge sub-module and the top.
package sim_trig_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    RUN  = 3'd2,
    DUMP = 3'd3,
    DONE = 3'd4
  } trig_state_e;

  localparam int CW_DEFAULT  = 32;
  localparam int SYNC_STAGES = 2;

endpackage

// File: rtl/sim_vs_edge.sv
// Multi-flop synchronizer for an asynchronous input.
// Emits either the synchronized level or a one-cycle falling-edge pulse.
module sim_vs_edge
  import sim_trig_pkg::*;
#(
  parameter bit RST_VAL   = 1'b0,
  parameter bit FALL_EDGE = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_i,
  output logic sig_o
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], async_i};
  end

  // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= {SYNC_STAGES{RST_VAL}};
    else        sync_q <= sync_d;
  end

  generate
    if (FALL_EDGE) begin : g_edge
      logic prev_q, prev_d;

      always_comb begin
        prev_d = sync_q[SYNC_STAGES-1];
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) prev_q <= RST_VAL;
        else        prev_q <= prev_d;
      end

      assign sig_o = prev_q & ~sync_q[SYNC_STAGES-1];
    end else begin : g_level
      assign sig_o = sync_q[SYNC_STAGES-1];
    end
  endgenerate

endmodule

// File: rtl/sim_frame_trigger.sv
// Frame counter and one-shot dump window / finish request driven by VGA vsync,
// gated on completion of the ROM download.
module sim_frame_trigger
  import sim_trig_pkg::*;
#(
  parameter int DUMP_START = 0,
  parameter int DUMP_LEN   = 0,
  parameter int MAX_FRAMES = 0,
  parameter bit WAIT_DL    = 1'b1,
  parameter int CW         = CW_DEFAULT
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          vs,
  input  logic          downloading,
  output logic [CW-1:0] frame_cnt,
  output logic          frame_stb,
  output logic          dump_on,
  output logic          dump_start_stb,
  output logic          dump_stop_stb,
  output logic          sim_finish
);

  localparam logic [CW-1:0] START_C = CW'(DUMP_START);
  localparam logic [CW-1:0] LEN_C   = CW'(DUMP_LEN);
  localparam logic [CW-1:0] MAX_C   = CW'(MAX_FRAMES);
  localparam trig_state_e   RESET_ST = WAIT_DL ? IDLE : RUN;

  logic vs_fall, dl_s;

  sim_vs_edge #(.RST_VAL(1'b1), .FALL_EDGE(1'b1)) u_vs_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .async_i (vs),
    .sig_o   (vs_fall)
  );

  sim_vs_edge #(.RST_VAL(1'b0), .FALL_EDGE(1'b0)) u_dl_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .async_i (downloading),
    .sig_o   (dl_s)
  );

  trig_state_e   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, win_q, win_d, cnt_inc, win_inc;
  logic          opened_q, opened_d, dump_on_q, dump_on_d, finish_q, finish_d;
  logic          frame_stb_q, frame_stb_d, start_stb_q, start_stb_d, stop_stb_q, stop_stb_d;
  logic          hit_max, hit_start, hit_len;

  always_comb begin
    // NOTE: every _d is given its hold value before the case so no path infers a latch.
    state_d     = state_q;
    cnt_d       = cnt_q;
    win_d       = win_q;
    opened_d    = opened_q;
    dump_on_d   = dump_on_q;
    finish_d    = finish_q;
    frame_stb_d = 1'b0;
    start_stb_d = 1'b0;
    stop_stb_d  = 1'b0;
    cnt_inc     = cnt_q + 1'b1;
    win_inc     = win_q + 1'b1;
    hit_max     = (MAX_FRAMES != 0) && (cnt_inc == MAX_C);
    hit_start   = !opened_q && (cnt_q == START_C);
    hit_len     = (DUMP_LEN != 0) && (win_inc == LEN_C);

    unique case (state_q)
      IDLE: if (dl_s)  state_d = LOAD;
      LOAD: if (!dl_s) state_d = RUN;
      RUN, DUMP: begin
        if (dl_s) begin
          // A new download pauses counting; the window latch survives the pause.
          state_d = LOAD;
          if (dump_on_q) begin
            dump_on_d  = 1'b0;
            stop_stb_d = 1'b1;
          end
        end else if (vs_fall) begin
          cnt_d       = cnt_inc;
          frame_stb_d = 1'b1;
          if (state_q == DUMP) win_d = win_inc;
          if (hit_max) begin
            state_d    = DONE;
            finish_d   = 1'b1;
            dump_on_d  = 1'b0;
            stop_stb_d = dump_on_q;
          end else if (state_q == RUN && hit_start) begin
            state_d     = DUMP;
            dump_on_d   = 1'b1;
            start_stb_d = 1'b1;
            opened_d    = 1'b1;
          end else if (state_q == DUMP && hit_len) begin
            state_d    = RUN;
            dump_on_d  = 1'b0;
            stop_stb_d = 1'b1;
          end
        end
      end
      DONE: begin
      end
      default: state_d = RESET_ST;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RESET_ST;
      cnt_q       <= '0;
      win_q       <= '0;
      opened_q    <= 1'b0;
      dump_on_q   <= 1'b0;
      finish_q    <= 1'b0;
      frame_stb_q <= 1'b0;
      start_stb_q <= 1'b0;
      stop_stb_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      win_q       <= win_d;
      opened_q    <= opened_d;
      dump_on_q   <= dump_on_d;
      finish_q    <= finish_d;
      frame_stb_q <= frame_stb_d;
      start_stb_q <= start_stb_d;
      stop_stb_q  <= stop_stb_d;
    end
  end

  assign frame_cnt      = cnt_q;
  assign frame_stb      = frame_stb_q;
  assign dump_on        = dump_on_q;
  assign dump_start_stb = start_stb_q;
  assign dump_stop_stb  = stop_stb_q;
  assign sim_finish     = finish_q;

endmodule

// File: tb/tb_sim_frame_trigger.sv
// Directed bench for sim_frame_trigger: three configurations exercising
// download gating, one-shot window, finish precedence, pause, wrap and reset.
module tb_sim_frame_trigger;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // A: WAIT_DL=1, window 3 (+2 frames), no finish
  logic rst_a_n, vs_a, dl_a;
  logic [31:0] cnt_a;
  logic stb_a, on_a, st_a, sp_a, fin_a;
  // B: window opens at 2, never closes, finish at 4
  logic rst_b_n, vs_b, dl_b;
  logic [31:0] cnt_b;
  logic stb_b, on_b, st_b, sp_b, fin_b;
  // C: 4-bit counter, no download gating
  logic rst_c_n, vs_c, dl_c;
  logic [3:0] cnt_c;
  logic stb_c, on_c, st_c, sp_c, fin_c;

  sim_frame_trigger #(.DUMP_START(3), .DUMP_LEN(2), .MAX_FRAMES(0), .WAIT_DL(1'b1), .CW(32)) u_a (
    .clk(clk), .rst_n(rst_a_n), .vs(vs_a), .downloading(dl_a), .frame_cnt(cnt_a),
    .frame_stb(stb_a), .dump_on(on_a), .dump_start_stb(st_a), .dump_stop_stb(sp_a), .sim_finish(fin_a));

  sim_frame_trigger #(.DUMP_START(2), .DUMP_LEN(0), .MAX_FRAMES(4), .WAIT_DL(1'b1), .CW(32)) u_b (
    .clk(clk), .rst_n(rst_b_n), .vs(vs_b), .downloading(dl_b), .frame_cnt(cnt_b),
    .frame_stb(stb_b), .dump_on(on_b), .dump_start_stb(st_b), .dump_stop_stb(sp_b), .sim_finish(fin_b));

  sim_frame_trigger #(.DUMP_START(0), .DUMP_LEN(0), .MAX_FRAMES(0), .WAIT_DL(1'b0), .CW(4)) u_c (
    .clk(clk), .rst_n(rst_c_n), .vs(vs_c), .downloading(dl_c), .frame_cnt(cnt_c),
    .frame_stb(stb_c), .dump_on(on_c), .dump_start_stb(st_c), .dump_stop_stb(sp_c), .sim_finish(fin_c));

  // Strobe tallies, sampled on the falling edge.
  int a_stb_n = 0, a_st_n = 0, a_sp_n = 0, b_sp_n = 0, b_st_n = 0;
  always @(negedge clk) begin
    if (stb_a) a_stb_n++;
    if (st_a)  a_st_n++;
    if (sp_a)  a_sp_n++;
    if (sp_b)  b_sp_n++;
    if (st_b)  b_st_n++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_vs(input int w, input logic v);
    case (w)
      0: vs_a = v;
      1: vs_b = v;
      default: vs_c = v;
    endcase
  endtask

  task automatic set_dl(input int w, input logic v);
    case (w)
      0: dl_a = v;
      1: dl_b = v;
      default: dl_c = v;
    endcase
  endtask

  function automatic logic [3:0] obs_stb(input int w);
    case (w)
      0: return {stb_a, st_a, sp_a, 1'b0};
      1: return {stb_b, st_b, sp_b, 1'b0};
      default: return {stb_c, st_c, sp_c, 1'b0};
    endcase
  endfunction

  // One vsync pulse; checks frame_stb lands exactly on clk edge 3 and is one cycle wide.
  task automatic pulse(input int w, input logic exp_stb, output logic st, output logic sp);
    logic [3:0] s;
    @(negedge clk); set_vs(w, 1'b0);
    @(negedge clk);
    @(negedge clk);
    s = obs_stb(w);
    check($sformatf("stb_before_edge3_%0d", w), 32'(s[3]), 32'd0);
    @(negedge clk);
    s = obs_stb(w);
    check($sformatf("stb_at_edge3_%0d", w), 32'(s[3]), 32'(exp_stb));
    st = s[2];
    sp = s[1];
    @(negedge clk);
    s = obs_stb(w);
    check($sformatf("stb_width_%0d", w), 32'(s[3]), 32'd0);
    set_vs(w, 1'b1);
    repeat (3) @(negedge clk);
  endtask

  task automatic download(input int w);
    @(negedge clk); set_dl(w, 1'b1);
    repeat (6) @(negedge clk);
    set_dl(w, 1'b0);
    repeat (6) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic st, sp;
    int snap_stb, snap_sp, snap_st;

    rst_a_n = 1'b0; rst_b_n = 1'b0; rst_c_n = 1'b0;
    vs_a = 1'b1; vs_b = 1'b1; vs_c = 1'b1;
    dl_a = 1'b0; dl_b = 1'b0; dl_c = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_cnt_a", cnt_a, 32'd0);
    check("reset_outs_a", {27'd0, stb_a, on_a, st_a, sp_a, fin_a}, 32'd0);
    check("reset_outs_c", {23'd0, cnt_c, stb_c, on_c, st_c, sp_c, fin_c}, 32'd0);
    rst_a_n = 1'b1; rst_b_n = 1'b1; rst_c_n = 1'b1;
    repeat (2) @(negedge clk);

    // A: frames before download are ignored
    for (int i = 0; i < 5; i++) pulse(0, 1'b0, st, sp);
    check("a_cnt_predl", cnt_a, 32'd0);
    download(0);
    #1 snap_stb = a_stb_n;
    for (int i = 1; i <= 8; i++) begin
      pulse(0, 1'b1, st, sp);
      check($sformatf("a_cnt_%0d", i), cnt_a, 32'(i));
      check($sformatf("a_start_%0d", i), 32'(st), 32'(i == 4));
      check($sformatf("a_stop_%0d", i), 32'(sp), 32'(i == 6));
      check($sformatf("a_on_%0d", i), 32'(on_a), 32'(i == 4 || i == 5));
      if (i == 5) begin
        #1 check("a_stb_count_5", 32'(a_stb_n - snap_stb), 32'd5);
      end
    end
    #1;
    check("a_start_total", 32'(a_st_n), 32'd1);
    check("a_stop_total", 32'(a_sp_n), 32'd1);
    check("a_fin", 32'(fin_a), 32'd0);

    // A: asynchronous reset while the window is open
    @(negedge clk); rst_a_n = 1'b0;
    @(negedge clk); rst_a_n = 1'b1;
    download(0);
    for (int i = 0; i < 4; i++) pulse(0, 1'b1, st, sp);
    check("a_reopen_after_reset", 32'(on_a), 32'd1);
    #1 snap_sp = a_sp_n;
    @(negedge clk); #2 rst_a_n = 1'b0;
    #1;
    check("a_async_cnt", cnt_a, 32'd0);
    check("a_async_outs", {27'd0, stb_a, on_a, st_a, sp_a, fin_a}, 32'd0);
    @(negedge clk); rst_a_n = 1'b1;
    repeat (3) @(negedge clk);
    #1 check("a_no_stop_on_reset", 32'(a_sp_n - snap_sp), 32'd0);
    pulse(0, 1'b0, st, sp);
    check("a_idle_after_reset", cnt_a, 32'd0);

    // B: finish overrides, closes the window with a single stop pulse
    download(1);
    for (int i = 1; i <= 4; i++) begin
      pulse(1, 1'b1, st, sp);
      check($sformatf("b_cnt_%0d", i), cnt_b, 32'(i));
      check($sformatf("b_start_%0d", i), 32'(st), 32'(i == 3));
      check($sformatf("b_stop_%0d", i), 32'(sp), 32'(i == 4));
      check($sformatf("b_fin_%0d", i), 32'(fin_b), 32'(i == 4));
    end
    pulse(1, 1'b0, st, sp);
    check("b_cnt_done", cnt_b, 32'd4);
    check("b_fin_sticky", 32'(fin_b), 32'd1);
    #1 check("b_stop_total", 32'(b_sp_n), 32'd1);

    // B: download re-asserted inside the window
    @(negedge clk); rst_b_n = 1'b0;
    @(negedge clk); rst_b_n = 1'b1;
    download(1);
    for (int i = 0; i < 3; i++) pulse(1, 1'b1, st, sp);
    check("b2_on_cnt3", 32'(on_b), 32'd1);
    #1 begin snap_sp = b_sp_n; snap_st = b_st_n; end
    @(negedge clk); dl_b = 1'b1;
    repeat (6) @(negedge clk);
    #1 check("b2_stop_on_dl", 32'(b_sp_n - snap_sp), 32'd1);
    check("b2_on_dropped", 32'(on_b), 32'd0);
    pulse(1, 1'b0, st, sp);
    check("b2_cnt_held", cnt_b, 32'd3);
    dl_b = 1'b0;
    repeat (6) @(negedge clk);
    pulse(1, 1'b1, st, sp);
    check("b2_cnt_resume", cnt_b, 32'd4);
    check("b2_no_reopen", 32'(on_b), 32'd0);
    #1 check("b2_start_total", 32'(b_st_n - snap_st), 32'd0);
    check("b2_stop_total", 32'(b_sp_n - snap_sp), 32'd1);
    check("b2_fin", 32'(fin_b), 32'd1);

    // C: 4-bit counter wraps, no finish
    for (int i = 1; i <= 17; i++) begin
      pulse(2, 1'b1, st, sp);
      if (i == 16) check("c_cnt_wrap0", 32'(cnt_c), 32'd0);
    end
    check("c_cnt_17", 32'(cnt_c), 32'd1);
    check("c_fin", 32'(fin_c), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
